wm8731_i2c_ctrl: RTL and testbench

Bit-level 2-wire control sequencer for the WM8731 codec. It accepts one register-write request (7-bit register address, 9-bit data) and builds the 25-bit control frame. It drives the load and shift strobes of the control shift register, takes that register's MSB back as the serial data source, and generates SCLK/SDIN with START, ACK slots and STOP. It sits between the configuration ROM/FSM upstream and the shift register plus codec pins downstream.

---
 rtl/wm8731_i2c_ctrl_if.sv | 13 +
 rtl/wm8731_i2c_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_wm8731_i2c_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wm8731_i2c_ctrl_if.sv
// Register-write request channel between the codec configuration sequencer
// (master) and the WM8731 2-wire control sequencer (slave).
interface wm8731_i2c_ctrl_if;
    logic       start;
    logic [6:0] reg_addr;
    logic [8:0] reg_data;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (output start, reg_addr, reg_data, input busy, done, ack_err);
    modport slave  (input start, reg_addr, reg_data, output busy, done, ack_err);
endinterface

// File: rtl/wm8731_i2c_ctrl.sv
// Bit-level 2-wire control sequencer for the WM8731: START, 3 bytes + ACK slots, STOP.
// Optional WM8731_ACK_CHECK_EN: a NACK sets ack_err and aborts straight to STOP.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus released (sclk=1, SDIN released), waiting for a request
// S_START | 2 quarters: SDIN falls with sclk high, then sclk falls
// S_BIT   | 4 quarters per payload bit, SDIN from shift register MSB
// S_ACK   | 4 quarters, SDIN released, codec ACK sampled in Q2
// S_STOP  | 3 quarters: SDIN rises while sclk is high
module wm8731_i2c_ctrl #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [6:0]  DEV_ADDR = 7'b0011010
) (
    input  logic              clk,
    input  logic              reset,
    wm8731_i2c_ctrl_if.slave  req,
    output logic [24:0]       frame,
    output logic              carrega,
    output logic              shift,
    input  logic              regout,
    output logic              sclk,
    output logic              sdin_oe,
    input  logic              sdin_in
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] Q_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] q_cnt, q_cnt_nxt;
    logic [1:0]  qtr, qtr_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [1:0]  byte_cnt, byte_cnt_nxt;
    logic        done_q, done_nxt;
    logic [24:0] frame_q, frame_new;
    logic        busy, accept, tick, stop_early;

    assign busy      = (state != S_IDLE);
    assign accept    = req.start & ~busy & ~done_q & reset;
    assign frame_new = {DEV_ADDR, 1'b0, req.reg_addr, req.reg_data, 1'b0};
    assign tick      = (q_cnt == Q_LAST);

    // New word is presented during the load strobe so the shift register captures it on the accept edge.
    assign frame    = accept ? frame_new : frame_q;
    assign carrega  = accept;
    assign req.busy = busy;
    assign req.done = done_q;

`ifdef WM8731_ACK_CHECK_EN
    logic ack_err_q, ack_smp;

    assign ack_smp     = (state == S_ACK) && (qtr == 2'd2) && (q_cnt == '0);
    assign stop_early  = ack_err_q;
    assign req.ack_err = ack_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_err_q <= 1'b0;
        end else if (accept) begin
            ack_err_q <= 1'b0;
        end else if (ack_smp && sdin_in) begin
            ack_err_q <= 1'b1;
        end
    end
`else
    logic unused_sdin_in;

    assign unused_sdin_in = sdin_in;
    assign stop_early     = 1'b0;
    assign req.ack_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            q_cnt    <= '0;
            qtr      <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            done_q   <= 1'b0;
            frame_q  <= '0;
        end else begin
            state    <= state_nxt;
            q_cnt    <= q_cnt_nxt;
            qtr      <= qtr_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            done_q   <= done_nxt;
            if (accept) begin
                frame_q <= frame_new;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        q_cnt_nxt    = q_cnt;
        qtr_nxt      = qtr;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        done_nxt     = 1'b0;
        shift        = 1'b0;

        if (state != S_IDLE) begin
            q_cnt_nxt = tick ? '0 : q_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt    = S_START;
                    q_cnt_nxt    = '0;
                    qtr_nxt      = '0;
                    bit_cnt_nxt  = '0;
                    byte_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    if (qtr == 2'd1) begin
                        state_nxt = S_BIT;
                        qtr_nxt   = '0;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        shift = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state_nxt   = S_ACK;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    if (qtr == 2'd3) begin
                        if ((byte_cnt == 2'd2) || stop_early) begin
                            state_nxt = S_STOP;
                        end else begin
                            state_nxt    = S_BIT;
                            byte_cnt_nxt = byte_cnt + 2'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    qtr_nxt = qtr + 2'd1;
                    if (qtr == 2'd2) begin
                        state_nxt = S_IDLE;
                        qtr_nxt   = '0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Line drivers decode from registered state, so a reset releases the bus without a clock.
    always_comb begin
        sclk    = 1'b1;
        sdin_oe = 1'b0;
        case (state)
            S_START: begin
                sclk    = (qtr == 2'd0);
                sdin_oe = 1'b1;
            end
            S_BIT: begin
                sclk    = (qtr == 2'd1) || (qtr == 2'd2);
                sdin_oe = ~regout;
            end
            S_ACK: begin
                sclk    = (qtr == 2'd1) || (qtr == 2'd2);
                sdin_oe = 1'b0;
            end
            S_STOP: begin
                sclk    = (qtr != 2'd0);
                sdin_oe = (qtr != 2'd2);
            end
            default: begin
                sclk    = 1'b1;
                sdin_oe = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_wm8731_i2c_ctrl.sv
// Directed bench for wm8731_i2c_ctrl: shift-register and codec slave models,
// bus protocol monitor, hand-computed frames and byte values.
module tb_wm8731_i2c_ctrl;
    localparam int CD       = 4;
    localparam int LAT_FULL = 113 * CD + 1;
    localparam int LAT_NACK = 41 * CD + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [24:0] frame;
    logic        carrega, shift, regout, sclk, sdin_oe, sdin_in;
    logic [24:0] sr = '0;
    logic        ack_drive = 1'b0;

    wm8731_i2c_ctrl_if req();

    wm8731_i2c_ctrl #(.CLK_DIV(CD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .frame   (frame),
        .carrega (carrega),
        .shift   (shift),
        .regout  (regout),
        .sclk    (sclk),
        .sdin_oe (sdin_oe),
        .sdin_in (sdin_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int shift_cnt = 0, carrega_cnt = 0, done_cnt = 0;
    int viol = 0, runs = 0;
    int mon_en = 0;
    int nack_byte = -1;
    logic [7:0] dec_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream control shift register
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (carrega) sr <= frame;
        else if (shift) sr <= {sr[23:0], 1'b0};
    end
    assign regout  = sr[24];
    assign sdin_in = ~(sdin_oe | ack_drive);

    always @(negedge clk) begin
        if (shift) shift_cnt++;
        if (carrega) carrega_cnt++;
        if (req.done) done_cnt++;
    end

    // Codec slave + protocol monitor, sampled away from the active edge
    bit         prev_sclk = 1'b1, prev_sda = 1'b1, in_frame = 1'b0, run_ok = 1'b0;
    int         bitpos = 0, byte_idx = 0, run_len = 0;
    logic [7:0] cur = '0;
    always @(negedge clk) begin
        bit sda;
        sda = sdin_in;
        if (!reset) begin
            in_frame  = 1'b0;
            bitpos    = 0;
            ack_drive = 1'b0;
            run_ok    = 1'b0;
        end else begin
            if (sclk && prev_sclk && (sda != prev_sda)) begin
                if (!sda) begin
                    if (in_frame && mon_en != 0) viol++;
                    in_frame = 1'b1;
                    bitpos   = 0;
                    byte_idx = 0;
                end else begin
                    if (!in_frame && mon_en != 0) viol++;
                    in_frame = 1'b0;
                    run_ok   = 1'b0;
                end
            end
            if (sclk != prev_sclk) begin
                if (mon_en != 0 && run_ok) begin
                    runs++;
                    if (run_len != 2 * CD) viol++;
                end
                run_len = 0;
                run_ok  = in_frame;
                if (sclk) begin
                    if (bitpos < 8) cur = {cur[6:0], sda};
                    else begin
                        dec_q.push_back(cur);
                        byte_idx++;
                    end
                    bitpos = (bitpos == 8) ? 0 : bitpos + 1;
                end else begin
                    ack_drive = (bitpos == 8) && (byte_idx != nack_byte);
                end
            end
            run_len++;
        end
        prev_sclk = sclk;
        prev_sda  = sda;
    end

    task automatic run_write(input logic [6:0] a, input logic [8:0] d, input logic [24:0] f,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input int nb, input int ns, input int lat, input logic err);
        int sb, cb, qb, acc, n;
        logic [7:0] eb[3];
        eb = '{b0, b1, b2};
        @(posedge clk); #1;
        sb = shift_cnt; cb = carrega_cnt; qb = dec_q.size();
        req.reg_addr = a; req.reg_data = d; req.start = 1'b1; acc = cyc;
        @(negedge clk);
        check_eq("accept_carrega", 32'(carrega), 32'd1);
        @(posedge clk); #1 req.start = 1'b0;
        @(negedge clk);
        check_eq("busy_after_accept", 32'(req.busy), 32'd1);
        check_eq("frame", 32'(frame), 32'(f));
        check_eq("ack_err_cleared", 32'(req.ack_err), 32'd0);
        n = 0;
        while (!req.done && n < 4 * LAT_FULL) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_latency", cyc - acc, lat);
        check_eq("busy_at_done", 32'(req.busy), 32'd0);
        check_eq("frame_hold", 32'(frame), 32'(f));
        check_eq("shift_count", shift_cnt - sb, ns);
        check_eq("carrega_count", carrega_cnt - cb, 32'd1);
        check_eq("ack_err", 32'(req.ack_err), 32'(err));
        check_eq("byte_count", dec_q.size() - qb, nb);
        if (dec_q.size() - qb >= nb) begin
            for (int i = 0; i < nb; i++) check_eq("sdin_byte", 32'(dec_q[qb + i]), 32'(eb[i]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sb, cb, db, vb, rb, acc, n;
        req.start = 1'b0; req.reg_addr = '0; req.reg_data = '0;
        repeat (3) @(negedge clk);
        req.start = 1'b1;
        @(negedge clk);
        check_eq("rst_sclk", 32'(sclk), 32'd1);
        check_eq("rst_sdin_oe", 32'(sdin_oe), 32'd0);
        check_eq("rst_busy", 32'(req.busy), 32'd0);
        check_eq("rst_done", 32'(req.done), 32'd0);
        check_eq("rst_carrega", 32'(carrega), 32'd0);
        check_eq("rst_shift", 32'(shift), 32'd0);
        check_eq("rst_frame", 32'(frame), 32'd0);
        check_eq("rst_ack_err", 32'(req.ack_err), 32'd0);
        @(posedge clk); #1 req.start = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);

        // Basic write: 0x34 0x0E 0x0A
        run_write(7'h07, 9'h00A, 25'h0681C14, 8'h34, 8'h0E, 8'h0A, 3, 24, LAT_FULL, 1'b0);

        // Busy rejection, then a start coinciding with done
        @(posedge clk); #1;
        sb = shift_cnt; cb = carrega_cnt; db = done_cnt;
        req.reg_addr = 7'h05; req.reg_data = 9'h1FF; req.start = 1'b1; acc = cyc;
        @(posedge clk); #1 req.start = 1'b0;
        repeat (40) @(posedge clk);
        #1 req.reg_addr = 7'h7F; req.reg_data = 9'h000; req.start = 1'b1;
        @(negedge clk);
        check_eq("busy_start_carrega", 32'(carrega), 32'd0);
        @(posedge clk); #1 req.start = 1'b0;
        @(negedge clk);
        check_eq("busy_frame_kept", 32'(frame), 32'h06817FE);
        while (cyc < acc + LAT_FULL - 1) @(negedge clk);
        @(posedge clk); #1 req.start = 1'b1;
        @(negedge clk);
        check_eq("done_cycle_done", 32'(req.done), 32'd1);
        check_eq("done_cycle_carrega", 32'(carrega), 32'd0);
        @(posedge clk); #1 req.start = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("done_cycle_busy", 32'(req.busy), 32'd0);
        check_eq("single_done", done_cnt - db, 32'd1);
        check_eq("single_carrega", carrega_cnt - cb, 32'd1);
        check_eq("busy_shifts", shift_cnt - sb, 32'd24);
        check_eq("busy_frame_end", 32'(frame), 32'h06817FE);

        // Codec NACKs the first byte
        nack_byte = 0;
`ifdef WM8731_ACK_CHECK_EN
        run_write(7'h07, 9'h00A, 25'h0681C14, 8'h34, 8'h0E, 8'h0A, 1, 8, LAT_NACK, 1'b1);
`else
        run_write(7'h07, 9'h00A, 25'h0681C14, 8'h34, 8'h0E, 8'h0A, 3, 24, LAT_FULL, 1'b0);
`endif
        nack_byte = -1;

        // Reset during bit 10
        @(posedge clk); #1;
        sb = shift_cnt;
        req.reg_addr = 7'h07; req.reg_data = 9'h00A; req.start = 1'b1;
        @(posedge clk); #1 req.start = 1'b0;
        n = 0;
        while (shift_cnt - sb < 9 && n < LAT_FULL) begin
            @(negedge clk);
            n++;
        end
        repeat (CD) @(negedge clk);
        check_eq("mid_busy", 32'(req.busy), 32'd1);
        check_eq("mid_sclk", 32'(sclk), 32'd1);
        check_eq("mid_sdin_oe", 32'(sdin_oe), 32'd1);
        db = done_cnt;
        #2 reset = 1'b0;
        #1;
        check_eq("async_sclk", 32'(sclk), 32'd1);
        check_eq("async_sdin_oe", 32'(sdin_oe), 32'd0);
        check_eq("async_busy", 32'(req.busy), 32'd0);
        check_eq("async_shift", 32'(shift), 32'd0);
        check_eq("async_frame", 32'(frame), 32'd0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("no_done_after_reset", done_cnt - db, 32'd0);
        run_write(7'h04, 9'h012, 25'h0681024, 8'h34, 8'h08, 8'h12, 3, 24, LAT_FULL, 1'b0);

        // Back-to-back writes under the protocol monitor
        vb = viol; rb = runs; mon_en = 1;
        run_write(7'h00, 9'h017, 25'h068002E, 8'h34, 8'h00, 8'h17, 3, 24, LAT_FULL, 1'b0);
        run_write(7'h02, 9'h179, 25'h0680AF2, 8'h34, 8'h05, 8'h79, 3, 24, LAT_FULL, 1'b0);
        run_write(7'h09, 9'h001, 25'h0682402, 8'h34, 8'h12, 8'h01, 3, 24, LAT_FULL, 1'b0);
        repeat (4) @(negedge clk);
        mon_en = 0;
        check_eq("protocol_violations", viol - vb, 32'd0);
        check_eq("sclk_runs_checked", runs - rb, 32'd165);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
